// File: rtl/silife_pkg.sv
// Shared encodings for the silife grid sequencer: host command opcodes,
// sequencer FSM state codes and the terminal row index.
package silife_pkg;

  localparam int          ROW_W     = 5;
  localparam logic [4:0]  ROWS_LAST = 5'd31;

  typedef enum logic [1:0] {
    OP_STEP  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_DUMP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STEP      = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT = 3'd2;
  localparam logic [2:0] S_LOAD_WR   = 3'd3;
  localparam logic [2:0] S_DUMP_ADDR = 3'd4;
  localparam logic [2:0] S_DUMP_OUT  = 3'd5;
  localparam logic [2:0] S_CLEAR     = 3'd6;

endpackage

// File: rtl/silife_step_timer.sv
// Auto-step period counter with a coalescing pending flag.
// Ports: i_en/i_period configure, i_consume clears pending, o_pending out.
module silife_step_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_consume,
  output logic                o_pending
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_pending;
  logic                w_run;
  logic                w_tick;

  assign w_run  = i_en & (i_period != '0);
  // >= keeps the wrap sane if the period shrinks below the count
  assign w_tick = w_run &
                  (r_cnt >= i_period - PERIOD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (!w_run || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + PERIOD_W'(1);
      // ticks arriving while pending are coalesced
      if (!i_en)
        r_pending <= 1'b0;
      else
        r_pending <= (r_pending & ~i_consume) | w_tick;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/silife_grid_sequencer.sv
// Shares silife core controls between host commands and the auto-step timer.
// Ports: cfg_*, cmd_*, ld_* (row load stream), dp_* (row dump stream), core_*.
module silife_grid_sequencer
  import silife_pkg::*;
#(
  parameter int ROWS     = 32,
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_auto_en,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [7:0]          ld_data,
  output logic                dp_valid,
  input  logic                dp_ready,
  output logic [7:0]          dp_data,
  output logic [4:0]          dp_row,
  output logic                dp_last,
  output logic [4:0]          core_row_select,
  output logic                core_max_en,
  output logic                core_en,
  output logic                core_wr_en,
  output logic [7:0]          core_data_in,
  input  logic [7:0]          core_data_out,
  output logic                busy,
  output logic [GEN_W-1:0]    gen_count
);

  logic [2:0]       r_state;
  logic [4:0]       r_row;
  logic [7:0]       r_data;
  logic [GEN_W-1:0] r_gen;

  logic w_idle;
  logic w_pending;
  logic w_consume;
  logic w_last;
  logic w_dump;

  assign w_idle    = (r_state == S_IDLE);
  assign w_last    = (r_row == 5'(ROWS - 1));
  // host command wins; auto-step only on a quiet idle cycle
  assign w_consume = w_idle & ~cmd_valid & w_pending;
  assign w_dump    = (r_state == S_DUMP_ADDR) |
                     (r_state == S_DUMP_OUT);

  silife_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_en      (cfg_auto_en),
    .i_period  (cfg_period),
    .i_consume (w_consume),
    .o_pending (w_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_data  <= '0;
      r_gen   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_row <= '0;
            unique case (cmd_op)
              OP_STEP: r_state <= S_STEP;
              OP_LOAD: r_state <= S_LOAD_WAIT;
              OP_DUMP: r_state <= S_DUMP_ADDR;
              OP_CLEAR: begin
                r_state <= S_CLEAR;
                r_data  <= '0;
                r_gen   <= '0;
              end
              default: r_state <= S_IDLE;
            endcase
          end else if (w_pending) begin
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_gen   <= r_gen + GEN_W'(1);
          r_state <= S_IDLE;
        end
        S_LOAD_WAIT: begin
          if (ld_valid) begin
            r_data  <= ld_data;
            r_state <= S_LOAD_WR;
          end
        end
        S_LOAD_WR: begin
          if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_row   <= r_row + 5'd1;
            r_state <= S_LOAD_WAIT;
          end
        end
        S_DUMP_ADDR: r_state <= S_DUMP_OUT;
        S_DUMP_OUT: begin
          if (dp_ready) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_row   <= r_row + 5'd1;
              r_state <= S_DUMP_ADDR;
            end
          end
        end
        S_CLEAR: begin
          if (w_last)
            r_state <= S_IDLE;
          else
            r_row <= r_row + 5'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = w_idle;
  assign busy      = ~w_idle;
  assign gen_count = r_gen;

  assign ld_ready  = (r_state == S_LOAD_WAIT);

  assign dp_valid  = (r_state == S_DUMP_OUT);
  assign dp_data   = dp_valid ? core_data_out : 8'd0;
  assign dp_row    = dp_valid ? r_row : 5'd0;
  assign dp_last   = dp_valid & w_last;

  assign core_row_select = r_row;
  assign core_data_in    = r_data;
  // display driver frozen so uo_out carries row data
  assign core_max_en     = ~w_dump;
  assign core_en         = (r_state == S_STEP);
  assign core_wr_en      = (r_state == S_LOAD_WR) |
                           (r_state == S_CLEAR);

endmodule

// File: tb/tb_silife_grid_sequencer.sv
// Scoreboard bench for silife_grid_sequencer with a simple core model.
// Drives host commands, row streams and the auto-step timer.
module tb_silife_grid_sequencer;
  import silife_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_auto_en = 1'b0;
  logic [23:0] cfg_period = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_data = '0;
  logic        dp_valid;
  logic        dp_ready = 1'b0;
  logic [7:0]  dp_data;
  logic [4:0]  dp_row;
  logic        dp_last;
  logic [4:0]  core_row_select;
  logic        core_max_en;
  logic        core_en;
  logic        core_wr_en;
  logic [7:0]  core_data_in;
  logic [7:0]  core_data_out;
  logic        busy;
  logic [15:0] gen_count;

  silife_grid_sequencer #(
    .ROWS (32), .PERIOD_W (24), .GEN_W (16)
  ) dut (
    .clk (clk), .rst (rst),
    .cfg_auto_en (cfg_auto_en), .cfg_period (cfg_period),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_op (cmd_op),
    .ld_valid (ld_valid), .ld_ready (ld_ready),
    .ld_data (ld_data),
    .dp_valid (dp_valid), .dp_ready (dp_ready),
    .dp_data (dp_data), .dp_row (dp_row), .dp_last (dp_last),
    .core_row_select (core_row_select),
    .core_max_en (core_max_en), .core_en (core_en),
    .core_wr_en (core_wr_en), .core_data_in (core_data_in),
    .core_data_out (core_data_out),
    .busy (busy), .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  // core model: frozen display returns inverted row index
  assign core_data_out = core_max_en ? 8'h5A
                                     : ~{3'b000, core_row_select};

  int n_chk = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int wr_cnt = 0;
  int exp_gen = 0;
  logic [12:0] q_wr[$];
  logic [13:0] q_dp[$];

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [12:0] e_wr;
    logic [13:0] e_dp;
    if (core_en) begin
      en_cnt++;
      chk("en_wr_excl", 32'(core_wr_en), 0);
      chk("en_in_dump", 32'(core_max_en), 1);
    end
    if (core_wr_en) begin
      wr_cnt++;
      if (q_wr.size() == 0) begin
        chk("wr_unexp", 1, 0);
      end else begin
        e_wr = q_wr.pop_front();
        chk("wr_row", 32'(core_row_select), 32'(e_wr[12:8]));
        chk("wr_data", 32'(core_data_in), 32'(e_wr[7:0]));
      end
    end
    if (dp_valid && dp_ready) begin
      if (q_dp.size() == 0) begin
        chk("dp_unexp", 1, 0);
      end else begin
        e_dp = q_dp.pop_front();
        chk("dp_last", 32'(dp_last), 32'(e_dp[13]));
        chk("dp_row", 32'(dp_row), 32'(e_dp[12:8]));
        chk("dp_data", 32'(dp_data), 32'(e_dp[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    int i;
    tick();
    cmd_valid = 1'b1;
    cmd_op    = op;
    i = 0;
    @(negedge clk);
    while (!cmd_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("cmd_to", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("idle_to", 32'(busy), 0);
  endtask

  task automatic do_dump(input int stall, input bit arm);
    int i;
    int base;
    for (int k = 0; k < 32; k++)
      q_dp.push_back({k == 31, 5'(k), ~{3'b000, 5'(k)}});
    send_cmd(OP_DUMP);
    base = en_cnt;
    dp_ready = 1'b0;
    repeat (stall) @(negedge clk);
    chk("dp_stall_max", 32'(core_max_en), 0);
    if (arm) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_STEP;
    end
    i = 0;
    do begin
      tick();
      dp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy) chk("dp_max_en", 32'(core_max_en), 0);
      i++;
    end while (busy && i < 400);
    dp_ready = 1'b0;
    chk("dump_to", 32'(busy), 0);
    chk("dump_max_back", 32'(core_max_en), 1);
    chk("dump_q_empty", 32'(q_dp.size()), 0);
    chk("dump_no_en", 32'(en_cnt - base), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b;
    int w0;
    int w1;
    int i;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(core_en), 0);
    chk("rst_wr", 32'(core_wr_en), 0);
    chk("rst_max", 32'(core_max_en), 1);
    chk("rst_ldr", 32'(ld_ready), 0);
    chk("rst_dpv", 32'(dp_valid), 0);
    chk("rst_gen", 32'(gen_count), 0);
    chk("rst_row", 32'(core_row_select), 0);
    chk("rst_din", 32'(core_data_in), 0);
    tick();
    rst = 1'b0;

    // single host step
    tick();
    cmd_valid = 1'b1;
    cmd_op    = OP_STEP;
    @(negedge clk);
    chk("step_rdy", 32'(cmd_ready), 1);
    chk("step_en0", 32'(core_en), 0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("step_en1", 32'(core_en), 1);
    chk("step_busy1", 32'(busy), 1);
    @(negedge clk);
    chk("step_en_end", 32'(core_en), 0);
    chk("step_busy0", 32'(busy), 0);
    exp_gen++;
    chk("step_gen", 32'(gen_count), 32'(exp_gen));

    // load 32 rows back to back
    w0 = wr_cnt;
    send_cmd(OP_LOAD);
    for (int k = 0; k < 32; k++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(k);
      q_wr.push_back({5'(k), 8'(k)});
      @(negedge clk);
      chk("ld_rdy1", 32'(ld_ready), 1);
      tick();
      ld_valid = 1'b0;
      @(negedge clk);
      chk("ld_rdy0", 32'(ld_ready), 0);
      tick();
    end
    @(negedge clk);
    chk("ld_done", 32'(busy), 0);
    chk("ld_wr_cnt", 32'(wr_cnt - w0), 32);
    chk("ld_q_empty", 32'(q_wr.size()), 0);

    // dump with random backpressure
    do_dump(0, 1'b0);

    // auto-step coalesced during a long dump
    tick();
    cfg_period  = 24'd10;
    cfg_auto_en = 1'b1;
    do_dump(40, 1'b0);
    b = en_cnt;
    tick();
    cfg_auto_en = 1'b0;
    @(negedge clk);
    chk("auto_en_now", 32'(core_en), 1);
    repeat (3) @(negedge clk);
    chk("auto_one", 32'(en_cnt - b), 1);
    exp_gen++;
    chk("auto_gen", 32'(gen_count), 32'(exp_gen));

    // host step beats pending auto-step
    tick();
    cfg_period  = 24'd4;
    cfg_auto_en = 1'b1;
    do_dump(20, 1'b1);
    b = en_cnt;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("host_first", 32'(core_en), 1);
    tick();
    tick();
    cfg_auto_en = 1'b0;
    @(negedge clk);
    chk("auto_second", 32'(core_en), 1);
    repeat (3) @(negedge clk);
    chk("two_steps", 32'(en_cnt - b), 2);
    exp_gen += 2;
    chk("two_gen", 32'(gen_count), 32'(exp_gen));

    // full clear
    for (int k = 0; k < 32; k++) q_wr.push_back({5'(k), 8'd0});
    send_cmd(OP_CLEAR);
    wait_idle(60);
    chk("clr_q_empty", 32'(q_wr.size()), 0);
    exp_gen = 0;
    chk("clr_gen", 32'(gen_count), 32'(exp_gen));
    for (int k = 0; k < 5; k++) begin
      send_cmd(OP_STEP);
      wait_idle(10);
    end
    exp_gen = 5;
    chk("gen5", 32'(gen_count), 32'(exp_gen));

    // reset in the middle of a clear
    for (int k = 0; k < 32; k++) q_wr.push_back({5'(k), 8'd0});
    w0 = wr_cnt;
    send_cmd(OP_CLEAR);
    i = 0;
    while (wr_cnt < w0 + 10 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("clr_progress", 32'(wr_cnt - w0), 10);
    tick();
    rst = 1'b1;
    q_wr.delete();
    @(negedge clk);
    w1 = wr_cnt;
    chk("mrst_wr", 32'(core_wr_en), 0);
    chk("mrst_max", 32'(core_max_en), 1);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_gen", 32'(gen_count), 0);
    chk("mrst_row", 32'(core_row_select), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_wr_after_rst", 32'(wr_cnt - w1), 0);
    chk("gen_after_rst", 32'(gen_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
